// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the pipeline registers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Pipeline-register hazard-control encoding
    localparam logic [1:0] HZ_NORMAL = 2'b00;
    localparam logic [1:0] HZ_FLUSH  = 2'b01;
    localparam logic [1:0] HZ_STALL  = 2'b10;

    // MDU occupancy FSM
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    // Resolved pipeline action, listed in priority order
    typedef enum logic [2:0] {
        ACT_MEM_WAIT = 3'd0,
        ACT_BRANCH   = 3'd1,
        ACT_MDU      = 3'd2,
        ACT_LOAD_USE = 3'd3,
        ACT_JUMP     = 3'd4,
        ACT_NONE     = 3'd5
    } hz_act_t;

    // Control bundle driven towards the PC and the pipeline registers
    typedef struct packed {
        logic       pc_wr;
        logic [1:0] if_id;
        logic [1:0] id_ex;
        logic [1:0] ex_mem;
    } hz_ctrl_t;

    // Map a resolved action onto the PC enable and register controls
    function automatic hz_ctrl_t act_to_ctrl(input hz_act_t act);
        hz_ctrl_t c;
        c = '{pc_wr: 1'b1, if_id: HZ_NORMAL, id_ex: HZ_NORMAL, ex_mem: HZ_NORMAL};
        case (act)
            ACT_MEM_WAIT: c = '{pc_wr: 1'b0, if_id: HZ_STALL, id_ex: HZ_STALL,  ex_mem: HZ_STALL};
            ACT_BRANCH:   c = '{pc_wr: 1'b1, if_id: HZ_FLUSH, id_ex: HZ_FLUSH,  ex_mem: HZ_NORMAL};
            ACT_MDU:      c = '{pc_wr: 1'b0, if_id: HZ_STALL, id_ex: HZ_FLUSH,  ex_mem: HZ_NORMAL};
            ACT_LOAD_USE: c = '{pc_wr: 1'b0, if_id: HZ_STALL, id_ex: HZ_FLUSH,  ex_mem: HZ_NORMAL};
            ACT_JUMP:     c = '{pc_wr: 1'b1, if_id: HZ_FLUSH, id_ex: HZ_NORMAL, ex_mem: HZ_NORMAL};
            default:      c = '{pc_wr: 1'b1, if_id: HZ_NORMAL, id_ex: HZ_NORMAL, ex_mem: HZ_NORMAL};
        endcase
        return c;
    endfunction

    // True when the instruction sitting in ID moves on into EX this cycle.
    // A jump flushes IF/ID (the fetched slot), not the jump itself.
    function automatic logic act_advances_id(input hz_act_t act);
        return (act == ACT_JUMP) || (act == ACT_NONE);
    endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// MDU occupancy timer: busy for MDU_LAT cycles after each accepted start pulse.
// Latency: busy rises the edge after start; last is combinational from the registered timer.
// Backpressure: none; the timer counts every cycle regardless of pipeline stalls.
module mdu_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic last
);

    localparam logic [7:0] LAT_LOAD = 8'(MDU_LAT);

    mdu_state_t state_q, state_d;
    logic [7:0] timer_q, timer_d;

    // State and timer registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state: load on start, count down while busy, drop out after the final cycle
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    timer_d = LAT_LOAD;
                end
            end
            ST_BUSY: begin
                if (start) begin
                    // Back-to-back MDU op accepted in the final busy cycle
                    state_d = ST_BUSY;
                    timer_d = LAT_LOAD;
                end else if (timer_q == 8'd1) begin
                    state_d = ST_IDLE;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = 8'd0;
            end
        endcase
    end

    assign busy = (state_q == ST_BUSY);
    // The final busy cycle is released early so a dependent op can issue into it
    assign last = busy && (timer_q == 8'd1);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: load-use, branch/jump redirect, memory wait and MDU occupancy.
// Latency: hazard controls combinational (act at next edge); MDU_Busy and Stall_Cnt registered.
// Backpressure: Mem_Wait freezes PC and all three pipeline registers for as long as it is high.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_RsAddr,
    input  logic [4:0]       ID_RtAddr,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsJump,
    input  logic             ID_IsMdu,
    input  logic             ID_ReadsHiLo,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_WrAddr,
    input  logic             EX_BranchTaken,
    input  logic             Mem_Wait,
    output logic             PC_Wr,
    output logic [1:0]       IF_ID_HzCtrl,
    output logic [1:0]       ID_EX_HzCtrl,
    output logic [1:0]       EX_MEM_HzCtrl,
    output logic             MDU_Start,
    output logic             MDU_Busy,
    output logic [CNT_W-1:0] Stall_Cnt
);

    logic       mdu_last;
    logic       rs_hit;
    logic       rt_hit;
    logic       load_use;
    logic       mdu_hazard;
    hz_act_t    act;
    hz_ctrl_t   ctrl;
    logic       mdu_start;
    logic [CNT_W-1:0] stall_cnt_q;

    mdu_busy_timer #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_timer (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_start),
        .busy  (MDU_Busy),
        .last  (mdu_last)
    );

    // Operand match against a load in EX; each address is qualified by its use flag
    // so undriven fields of non-reading instructions cannot create a hazard.
    always_comb begin
        rs_hit     = ID_UsesRs && (ID_RsAddr == EX_WrAddr);
        rt_hit     = ID_UsesRt && (ID_RtAddr == EX_WrAddr);
        load_use   = EX_MemRead && EX_RegWrite && (EX_WrAddr != 5'd0) && (rs_hit || rt_hit);
        mdu_hazard = MDU_Busy && !mdu_last && (ID_IsMdu || ID_ReadsHiLo);
    end

    // Priority resolution and output drive; reset forces everything quiet
    always_comb begin
        act = ACT_NONE;
        if (Mem_Wait) begin
            act = ACT_MEM_WAIT;
        end else if (EX_BranchTaken) begin
            act = ACT_BRANCH;
        end else if (mdu_hazard) begin
            act = ACT_MDU;
        end else if (load_use) begin
            act = ACT_LOAD_USE;
        end else if (ID_IsJump) begin
            act = ACT_JUMP;
        end
        ctrl      = act_to_ctrl(act);
        mdu_start = ID_IsMdu && act_advances_id(act);
        if (rst) begin
            ctrl      = '{pc_wr: 1'b0, if_id: HZ_NORMAL, id_ex: HZ_NORMAL, ex_mem: HZ_NORMAL};
            mdu_start = 1'b0;
        end
    end

    assign PC_Wr         = ctrl.pc_wr;
    assign IF_ID_HzCtrl  = ctrl.if_id;
    assign ID_EX_HzCtrl  = ctrl.id_ex;
    assign EX_MEM_HzCtrl = ctrl.ex_mem;
    assign MDU_Start     = mdu_start;

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (!ctrl.pc_wr && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] ID_RsAddr, ID_RtAddr, EX_WrAddr;
    logic       ID_UsesRs, ID_UsesRt, ID_IsJump, ID_IsMdu, ID_ReadsHiLo;
    logic       EX_MemRead, EX_RegWrite, EX_BranchTaken, Mem_Wait;

    // Instance A: short MDU latency, narrow counter (saturation reachable)
    logic       a_pc, a_start, a_busy;
    logic [1:0] a_ifid, a_idex, a_exmem;
    logic [3:0] a_cnt;
    // Instance B: long MDU latency, full-width counter
    logic       b_pc, b_start, b_busy;
    logic [1:0] b_ifid, b_idex, b_exmem;
    logic [31:0] b_cnt;

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsJump(ID_IsJump), .ID_IsMdu(ID_IsMdu), .ID_ReadsHiLo(ID_ReadsHiLo),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WrAddr(EX_WrAddr),
        .EX_BranchTaken(EX_BranchTaken), .Mem_Wait(Mem_Wait),
        .PC_Wr(a_pc), .IF_ID_HzCtrl(a_ifid), .ID_EX_HzCtrl(a_idex), .EX_MEM_HzCtrl(a_exmem),
        .MDU_Start(a_start), .MDU_Busy(a_busy), .Stall_Cnt(a_cnt)
    );

    hazard_ctrl #(.MDU_LAT(12), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst),
        .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsJump(ID_IsJump), .ID_IsMdu(ID_IsMdu), .ID_ReadsHiLo(ID_ReadsHiLo),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WrAddr(EX_WrAddr),
        .EX_BranchTaken(EX_BranchTaken), .Mem_Wait(Mem_Wait),
        .PC_Wr(b_pc), .IF_ID_HzCtrl(b_ifid), .ID_EX_HzCtrl(b_idex), .EX_MEM_HzCtrl(b_exmem),
        .MDU_Start(b_start), .MDU_Busy(b_busy), .Stall_Cnt(b_cnt)
    );

    wire [6:0] a_hz = {a_pc, a_ifid, a_idex, a_exmem};
    wire [6:0] b_hz = {b_pc, b_ifid, b_idex, b_exmem};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cycles of MDU occupancy remaining and stall count per instance
    int      m_lat [2] = '{4, 12};
    longint  m_max [2] = '{15, 64'hFFFF_FFFF};
    int      m_left[2];
    longint  m_cnt [2];

    typedef struct packed {
        logic       pc;
        logic [1:0] ifid;
        logic [1:0] idex;
        logic [1:0] exmem;
        logic       start;
    } exp_t;

    // Expected combinational outputs from the priority rules of the controller
    function automatic exp_t model_out(input int k);
        exp_t e;
        bit busy_eff, lu, mh;
        busy_eff = (m_left[k] > 1);
        lu = EX_MemRead && EX_RegWrite && (EX_WrAddr != 0) &&
             ((ID_UsesRs && ID_RsAddr == EX_WrAddr) || (ID_UsesRt && ID_RtAddr == EX_WrAddr));
        mh = busy_eff && (ID_IsMdu || ID_ReadsHiLo);
        e = '0;
        if (rst)                 e = '0;
        else if (Mem_Wait)       e = {1'b0, 2'b10, 2'b10, 2'b10, 1'b0};
        else if (EX_BranchTaken) e = {1'b1, 2'b01, 2'b01, 2'b00, 1'b0};
        else if (mh || lu)       e = {1'b0, 2'b10, 2'b01, 2'b00, 1'b0};
        else if (ID_IsJump)      e = {1'b1, 2'b01, 2'b00, 2'b00, ID_IsMdu};
        else                     e = {1'b1, 2'b00, 2'b00, 2'b00, ID_IsMdu};
        return e;
    endfunction

    function automatic void model_step(input int k, input exp_t e);
        if (rst) begin
            m_left[k] = 0;
            m_cnt[k]  = 0;
        end else begin
            if (e.start)           m_left[k] = m_lat[k];
            else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
            if (!e.pc && m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
        end
    endfunction

    // Advance one clock edge, updating the model with the pre-edge inputs
    task automatic tick();
        exp_t e0, e1;
        e0 = model_out(0);
        e1 = model_out(1);
        @(posedge clk);
        model_step(0, e0);
        model_step(1, e1);
        #1;
    endtask

    task automatic clear_inputs();
        ID_RsAddr = 0; ID_RtAddr = 0; EX_WrAddr = 0;
        ID_UsesRs = 0; ID_UsesRt = 0; ID_IsJump = 0; ID_IsMdu = 0; ID_ReadsHiLo = 0;
        EX_MemRead = 0; EX_RegWrite = 0; EX_BranchTaken = 0; Mem_Wait = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic randomize_inputs();
        ID_RsAddr = 5'($urandom_range(0, 3)); ID_RtAddr = 5'($urandom_range(0, 3));
        EX_WrAddr = 5'($urandom_range(0, 3));
        ID_UsesRs = 1'($urandom); ID_UsesRt = 1'($urandom);
        ID_IsJump = ($urandom_range(0, 5) == 0); ID_IsMdu = ($urandom_range(0, 5) == 0);
        ID_ReadsHiLo = ($urandom_range(0, 3) == 0);
        EX_MemRead = 1'($urandom); EX_RegWrite = 1'($urandom);
        EX_BranchTaken = ($urandom_range(0, 7) == 0); Mem_Wait = ($urandom_range(0, 7) == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        randomize_inputs();
        tick();
        tick();
        n_cmp++; if ({a_hz, a_start} !== 8'h00) begin n_err++; $display("FAIL reset_a_ctrl got=%b exp=%b", {a_hz, a_start}, 8'h00); end
        n_cmp++; if ({b_hz, b_start} !== 8'h00) begin n_err++; $display("FAIL reset_b_ctrl got=%b exp=%b", {b_hz, b_start}, 8'h00); end
        n_cmp++; if ({a_busy, b_busy} !== 2'b00) begin n_err++; $display("FAIL reset_busy got=%b exp=00", {a_busy, b_busy}); end
        n_cmp++; if (a_cnt !== 4'd0 || b_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        EX_MemRead = 1; EX_RegWrite = 1; EX_WrAddr = 5; ID_RsAddr = 5; ID_UsesRs = 1;
        #1;
        n_cmp++; if (a_hz !== 7'b0_10_01_00) begin n_err++; $display("FAIL lu_stall got=%b exp=%b", a_hz, 7'b0_10_01_00); end
        tick();
        n_cmp++; if (a_cnt !== 4'd1 || b_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt got=%0d/%0d exp=1/1", a_cnt, b_cnt); end
        EX_WrAddr = 0; ID_RsAddr = 0;
        #1;
        n_cmp++; if (a_hz !== 7'b1_00_00_00) begin n_err++; $display("FAIL lu_r0 got=%b exp=%b", a_hz, 7'b1_00_00_00); end
        EX_WrAddr = 9; ID_RsAddr = 3; ID_UsesRs = 0; ID_RtAddr = 9; ID_UsesRt = 1;
        #1;
        n_cmp++; if (b_hz !== 7'b0_10_01_00) begin n_err++; $display("FAIL lu_rt got=%b exp=%b", b_hz, 7'b0_10_01_00); end
        ID_UsesRt = 0;
        #1;
        n_cmp++; if (b_hz !== 7'b1_00_00_00) begin n_err++; $display("FAIL lu_unused got=%b exp=%b", b_hz, 7'b1_00_00_00); end
        tick();
        n_cmp++; if (a_cnt !== 4'd1) begin n_err++; $display("FAIL lu_cnt_hold got=%0d exp=1", a_cnt); end
    endtask

    task automatic test_branch_vs_lu();
        do_reset();
        EX_MemRead = 1; EX_RegWrite = 1; EX_WrAddr = 7; ID_RsAddr = 7; ID_UsesRs = 1; EX_BranchTaken = 1;
        #1;
        n_cmp++; if (a_hz !== 7'b1_01_01_00) begin n_err++; $display("FAIL br_over_lu got=%b exp=%b", a_hz, 7'b1_01_01_00); end
        tick();
        n_cmp++; if (a_cnt !== 4'd0) begin n_err++; $display("FAIL br_cnt got=%0d exp=0", a_cnt); end
    endtask

    task automatic test_memwait_branch();
        do_reset();
        EX_BranchTaken = 1; Mem_Wait = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (a_hz !== 7'b0_10_10_10) begin n_err++; $display("FAIL mw_freeze c=%0d got=%b exp=%b", c, a_hz, 7'b0_10_10_10); end
            tick();
        end
        Mem_Wait = 0;
        #1;
        n_cmp++; if (a_hz !== 7'b1_01_01_00) begin n_err++; $display("FAIL mw_then_br got=%b exp=%b", a_hz, 7'b1_01_01_00); end
        n_cmp++; if (b_cnt !== 32'd3) begin n_err++; $display("FAIL mw_cnt got=%0d exp=3", b_cnt); end
        tick();
    endtask

    task automatic test_mdu();
        exp_t eb;
        do_reset();
        ID_IsMdu = 1;
        #1;
        n_cmp++; if ({a_hz, a_start} !== {7'b1_00_00_00, 1'b1}) begin n_err++; $display("FAIL mdu_accept got=%b exp=%b", {a_hz, a_start}, 8'b1000_0001); end
        tick();
        ID_IsMdu = 0; ID_ReadsHiLo = 1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_cmp++; if (a_hz !== ((c <= 3) ? 7'b0_10_01_00 : 7'b1_00_00_00)) begin n_err++; $display("FAIL mdu_hilo c=%0d got=%b", c, a_hz); end
            n_cmp++; if (a_busy !== (c <= 4)) begin n_err++; $display("FAIL mdu_busy c=%0d got=%b exp=%b", c, a_busy, (c <= 4)); end
            n_cmp++; if (a_start !== 1'b0) begin n_err++; $display("FAIL mdu_nostart c=%0d got=%b exp=0", c, a_start); end
            eb = model_out(1);
            n_cmp++; if ({b_hz, b_start} !== eb) begin n_err++; $display("FAIL mdu_b c=%0d got=%b exp=%b", c, {b_hz, b_start}, eb); end
            tick();
        end
        n_cmp++; if (a_cnt !== 4'd3) begin n_err++; $display("FAIL mdu_cnt got=%0d exp=3", a_cnt); end
    endtask

    task automatic test_mdu_flush();
        do_reset();
        ID_IsMdu = 1; EX_BranchTaken = 1;
        #1;
        n_cmp++; if (a_start !== 1'b0) begin n_err++; $display("FAIL mdu_br_start got=%b exp=0", a_start); end
        tick();
        n_cmp++; if ({a_busy, b_busy} !== 2'b00) begin n_err++; $display("FAIL mdu_br_busy got=%b exp=00", {a_busy, b_busy}); end
        EX_BranchTaken = 0; ID_IsJump = 1;
        #1;
        n_cmp++; if ({a_hz, a_start} !== {7'b1_01_00_00, 1'b1}) begin n_err++; $display("FAIL mdu_jump got=%b exp=%b", {a_hz, a_start}, 8'b1010_0001); end
        tick();
        n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL mdu_jump_busy got=%b exp=1", a_busy); end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        ID_IsMdu = 1;
        tick();
        ID_IsMdu = 0;
        tick();
        tick();
        n_cmp++; if (b_busy !== 1'b1) begin n_err++; $display("FAIL rmb_busy_pre got=%b exp=1", b_busy); end
        rst = 1; Mem_Wait = 1; ID_ReadsHiLo = 1; ID_IsMdu = 1;
        #1;
        n_cmp++; if ({b_hz, b_start} !== 8'h00) begin n_err++; $display("FAIL rmb_ctrl got=%b exp=0", {b_hz, b_start}); end
        tick();
        rst = 0;
        clear_inputs();
        #1;
        n_cmp++; if ({a_busy, b_busy} !== 2'b00) begin n_err++; $display("FAIL rmb_busy got=%b exp=00", {a_busy, b_busy}); end
        n_cmp++; if (b_cnt !== 32'd0 || a_cnt !== 4'd0) begin n_err++; $display("FAIL rmb_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
        n_cmp++; if (b_hz !== 7'b1_00_00_00) begin n_err++; $display("FAIL rmb_after got=%b exp=%b", b_hz, 7'b1_00_00_00); end
    endtask

    task automatic test_saturation();
        do_reset();
        Mem_Wait = 1;
        repeat (15) tick();
        n_cmp++; if (a_cnt !== 4'hF) begin n_err++; $display("FAIL sat_reach got=%h exp=f", a_cnt); end
        repeat (2) tick();
        n_cmp++; if (a_cnt !== 4'hF) begin n_err++; $display("FAIL sat_hold got=%h exp=f", a_cnt); end
        n_cmp++; if (b_cnt !== 32'd17) begin n_err++; $display("FAIL sat_wide got=%0d exp=17", b_cnt); end
    endtask

    task automatic test_random();
        exp_t ea, eb;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 59) == 0);
            #1;
            ea = model_out(0);
            eb = model_out(1);
            n_cmp++; if ({a_hz, a_start} !== ea) begin n_err++; $display("FAIL rnd_a i=%0d got=%b exp=%b", i, {a_hz, a_start}, ea); end
            n_cmp++; if ({b_hz, b_start} !== eb) begin n_err++; $display("FAIL rnd_b i=%0d got=%b exp=%b", i, {b_hz, b_start}, eb); end
            n_cmp++; if ({a_busy, b_busy} !== {m_left[0] > 0, m_left[1] > 0}) begin n_err++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, {a_busy, b_busy}, {m_left[0] > 0, m_left[1] > 0}); end
            n_cmp++; if (longint'(a_cnt) != m_cnt[0] || longint'(b_cnt) != m_cnt[1]) begin n_err++; $display("FAIL rnd_cnt i=%0d got=%0d/%0d exp=%0d/%0d", i, a_cnt, b_cnt, m_cnt[0], m_cnt[1]); end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        m_left = '{0, 0};
        m_cnt  = '{0, 0};
        test_reset();
        test_load_use();
        test_branch_vs_lu();
        test_memwait_branch();
        test_mdu();
        test_mdu_flush();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
